// File: rtl/seq_mult8_pkg.sv
// Shared types and constants for the sequential 8x8 shift-and-add multiplier.
// State encoding, iteration bound and product width live here so top and bench agree.
package seq_mult8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LAST_ITER = 7;
    localparam int PROD_W    = 16;

endpackage

// File: rtl/seq_mult8_add.sv
// 8-bit ripple-carry adder, combinational (0 cycles), no flow control.
// Width is fixed at 8; the multiplier's WIDTH parameter does not resize it.
module seq_mult8_add (
    output logic [7:0] s,
    output logic       Carry_out,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       Carry_in
);

    logic [8:0] c;

    assign c[0] = Carry_in;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign Carry_out = c[8];

endmodule

// File: rtl/seq_mult8.sv
// Unsigned 8x8 shift-and-add multiplier: product valid 8 cycles after accept.
// Backpressure: in_ready only in IDLE; product/out_valid hold in DONE until out_ready.
module seq_mult8
    import seq_mult8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_ITER);

    state_t           state_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] add_s;
    logic             add_co;

    assign add_y = q_q[0] ? m_q : '0;

    seq_mult8_add u_add (
        .s         (add_s),
        .Carry_out (add_co),
        .x         (acc_q),
        .y         (add_y),
        .Carry_in  (1'b0)
    );

    // {carry, sum, Q} shifted right by one; the carry must land in ACC MSB.
    always_comb begin
        acc_d = {add_co, add_s[WIDTH-1:1]};
        q_d   = {add_s[0], q_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m_q     <= a;
                        q_q     <= b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = {acc_q, q_q};

endmodule

// File: tb/tb_seq_mult8.sv
// Bench for seq_mult8: directed corners, mid-operation reset and a randomized
// stream scored against plain a*b arithmetic.
module tb_seq_mult8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_mult8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, measure latency, optional stall, handshake.
    task automatic do_txn(input logic [7:0] av, input logic [7:0] bv,
                          input int stall, input bit pulse);
        logic [15:0] exp_p;
        logic [15:0] held;
        int          cyc;
        exp_p = 16'(av) * 16'(bv);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        step();
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        chk("busy_calc", 32'(busy), 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            if (pulse && cyc == 2) begin
                in_valid = 1'b1;
                a = 8'd1;
                b = 8'd1;
                chk("in_ready_calc", 32'(in_ready), 32'd0);
            end
            step();
            in_valid = 1'b0;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd8);
        chk("product", 32'(product), 32'(exp_p));
        held = product;
        repeat (stall) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_product", 32'(product), 32'(held));
            chk("in_ready_done", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] held;
        logic        held_vld;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          sent;
        int          got;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_txn(8'd13, 8'd11, 0, 1'b0);
        do_txn(8'd255, 8'd255, 0, 1'b0);
        do_txn(8'd0, 8'd200, 0, 1'b1);
        do_txn(8'd200, 8'd0, 0, 1'b0);
        do_txn(8'd100, 8'd3, 5, 1'b0);
        do_txn(8'd1, 8'd255, 0, 1'b0);
        do_txn(8'd128, 8'd2, 1, 1'b0);

        // Reset during the 4th CALC cycle must drop everything without a clock.
        in_valid = 1'b1;
        a = 8'd77;
        b = 8'd99;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_txn(8'd6, 8'd7, 0, 1'b0);

        // Randomized stream with random input gaps and output stalls.
        sent     = 0;
        got      = 0;
        held_vld = 1'b0;
        held     = '0;
        for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
            if (held_vld) begin
                chk("rand_hold_valid", 32'(out_valid), 32'd1);
                chk("rand_hold_product", 32'(product), 32'(held));
            end
            ra        = 8'($urandom);
            rb        = 8'($urandom);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a         = ra;
            b         = rb;
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(16'(ra) * 16'(rb));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("rand_pending", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("rand_product", 32'(product), 32'(exp_q.pop_front()));
                end
                got++;
            end
            held_vld = out_valid && !out_ready;
            held     = product;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand_results", 32'(got), 32'd1000);
        chk("rand_accepted", 32'(sent), 32'd1000);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult8.md
Name: seq_mult8

Overview:
- 8x8 unsigned shift-and-add multiplier.
- Owns the control sequencing, operand registers and partial-product registers.
- Issues one 8-bit addition per cycle to a ripple-carry adder and consumes its sum and carry-out.
- Sits directly upstream and downstream of the adder. Presents a valid/ready operand interface and a valid/ready 16-bit product interface.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported because the adder instance is fixed at 8 bits. The parameter exists for counter and port sizing only.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a and b are presented
- in_ready  output  1  block can accept operands
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  product is available
- out_ready  input  1  consumer accepts the product
- product  output  16  a*b, unsigned
- busy  output  1  high in CALC or DONE

Behaviour:
- Single clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - State = IDLE.
  - M, Q and ACC registers = 0; counter = 0.
  - out_valid = 0; product = 0; busy = 0.
  - in_ready = 1, since it is decoded from state.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: M <= a, Q <= b, ACC <= 0, cnt <= 0, go to CALC.
  - Operand values after the accept edge are don't-care.
- CALC:
  - in_ready = 0; in_valid is ignored.
  - Adder inputs: x = ACC, y = Q[0] ? M : 0, carry-in = 0.
  - Each edge: ACC <= {carry_out, sum[7:1]}; Q <= {sum[0], Q[7:1]}; cnt <= cnt + 1.
  - This is a 17-bit {carry, sum, Q} right shift by one.
  - When cnt == 7 at an edge, the final iteration completes and the FSM goes to DONE.
- DONE:
  - out_valid = 1; product = {ACC, Q}.
  - On out_ready, go to IDLE.
  - With out_ready low, product and out_valid hold indefinitely, stable bit-for-bit.
- Latency:
  - Accept edge E0, iterations at E1..E8.
  - out_valid is high after E8, i.e. 8 cycles after accept.
  - Earliest next accept is the edge after the out_ready handshake, giving a minimum 10-cycle issue interval.
- No accept in the same cycle as the DONE handshake; in_ready stays 0 in DONE.
- Width rule:
  - The carry-out of every add must be captured into ACC[7].
  - The maximum product 255*255 = 0xFE01 requires it.
  - No truncation anywhere.
- Zero operands: the FSM still runs the full 8 iterations, with no early exit, so latency is constant.
- Reset mid-operation (any state): asynchronously returns to IDLE with all reset values.
  - The in-flight product is discarded and out_valid drops immediately.
- out_ready high outside DONE: ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - Iteration count constant LAST_ITER = 7.
  - Product width constant = 16.
- One sub-module is natural: the 8-bit ripple-carry adder (instance name u_add).
  - Ports: s, Carry_out, x, y, Carry_in.
  - Carry_in is tied to 0.
- Control FSM and shift registers stay in seq_mult8.

Test Plan:
- a=13, b=11 → out_valid rises exactly 8 cycles after the accept edge; product = 143 (0x008F).
- a=255, b=255 → product = 0xFE01. Checks that the carry-out is captured on the iterations that generate one.
- a=0, b=200 and a=200, b=0 → product = 0 after the full 8-cycle latency. Pulse in_valid during CALC with a=1, b=1 → no effect, in_ready stays 0.
- a=100, b=3 with out_ready held low 5 cycles after out_valid → product = 300 (0x012C) held stable with out_valid high. Handshake → IDLE, in_ready = 1 next cycle.
- a=77, b=99 and assert rst_n low during the 4th CALC cycle → out_valid = 0, product = 0, in_ready = 1 asynchronously. Then a=6, b=7 → 42.
- Randomised back-to-back transactions with random out_ready stalls, 1000+ pairs plus corners 1*255 and 128*2 → every product matches a*b, with no lost or duplicated results.
